// File: rtl/regs_pkg.sv
// Shared register-file definitions: widths, the zero register, and the
// write-back record used by the arbiter, register file and decode stall logic.
package regs_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int NREGS  = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic [REG_DW-1:0] data;
    } wb_rec_t;

    // One-hot register mask; $0 maps to an empty mask since it is never written.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
        logic [NREGS-1:0] m;
        m = {NREGS{1'b0}};
        if (r != REG_ZERO) begin
            m[r] = 1'b1;
        end else begin
            m = {NREGS{1'b0}};
        end
        return m;
    endfunction

endpackage

// File: rtl/regs_wb_arb_if.sv
// Producer and register-file write-port signals of the write-back arbiter.
interface regs_wb_arb_if;
    import regs_pkg::*;

    logic              alu_we;
    logic [REG_AW-1:0] alu_dst;
    logic [REG_DW-1:0] alu_data;
    logic              alu_stall;
    logic              md_valid;
    logic              md_ready;
    logic [REG_AW-1:0] md_dst;
    logic [REG_DW-1:0] md_data;
    logic              regwrite;
    logic [REG_AW-1:0] write;
    logic [REG_DW-1:0] writedata;
    logic [NREGS-1:0]  pending;

    modport slave (
        input  alu_we, alu_dst, alu_data, md_valid, md_dst, md_data,
        output alu_stall, md_ready, regwrite, write, writedata, pending
    );

    modport master (
        output alu_we, alu_dst, alu_data, md_valid, md_dst, md_data,
        input  alu_stall, md_ready, regwrite, write, writedata, pending
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of write-back records with occupancy and a mask of the
// destinations held in valid entries.
module wb_fifo
    import regs_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_rec_t          din,
    input  logic             pop,
    output wb_rec_t          head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic [NREGS-1:0] dst_mask
);

    wb_rec_t       mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [PW-1:0] offs_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(wb_rec_t){1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry i is live when its distance from the read pointer is below count.
    always_comb begin
        dst_mask = {NREGS{1'b0}};
        offs_s   = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            offs_s = PW'(i) - rd_ptr_r;
            if ({1'b0, offs_s} < count_r) begin
                dst_mask = dst_mask | reg_onehot(mem_r[i].dst);
            end else begin
                dst_mask = dst_mask;
            end
        end
    end

endmodule

// File: rtl/regs_wb_arb.sv
// Write-back arbiter: merges the single-cycle ALU and the queued mul/div unit
// onto one registered register-file write port, with an anti-starvation bound.
module regs_wb_arb
    import regs_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 7
) (
    input logic          clk,
    input logic          rst,
    regs_wb_arb_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic              alu_eff_s;
    logic              md_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              load_s;
    logic              sel_alu_s;
    logic              stall_s;
    logic [SW-1:0]     starve_r;
    logic [SW-1:0]     starve_nxt_s;
    wb_rec_t           fifo_in_s;
    wb_rec_t           head_s;
    wb_rec_t           out_rec_s;
    logic [CW-1:0]     count_s;
    logic              full_s;
    logic              empty_s;
    logic [NREGS-1:0]  qmask_s;
    logic              regwrite_r;
    logic [REG_AW-1:0] write_r;
    logic [REG_DW-1:0] writedata_r;

    assign alu_eff_s  = bus.alu_we && (bus.alu_dst != REG_ZERO);
    assign md_ready_s = !rst && (count_s < CW'(DEPTH));
    // Transfers to $0 complete the handshake but are never stored.
    assign push_s     = bus.md_valid && md_ready_s && !full_s && (bus.md_dst != REG_ZERO);
    assign fifo_in_s  = '{dst: bus.md_dst, data: bus.md_data};
    assign out_rec_s  = sel_alu_s ? wb_rec_t'{dst: bus.alu_dst, data: bus.alu_data} : head_s;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .din      (fifo_in_s),
        .pop      (pop_s),
        .head     (head_s),
        .count    (count_s),
        .full     (full_s),
        .empty    (empty_s),
        .dst_mask (qmask_s)
    );

    // Priority: starved FIFO head, then ALU, then FIFO.
    always_comb begin
        pop_s        = 1'b0;
        load_s       = 1'b0;
        sel_alu_s    = 1'b0;
        stall_s      = 1'b0;
        starve_nxt_s = starve_r;
        if (!empty_s && (starve_r == SW'(STARVE_MAX))) begin
            pop_s        = 1'b1;
            load_s       = 1'b1;
            stall_s      = alu_eff_s;
            starve_nxt_s = {SW{1'b0}};
        end else if (alu_eff_s) begin
            load_s    = 1'b1;
            sel_alu_s = 1'b1;
            if (empty_s) begin
                starve_nxt_s = {SW{1'b0}};
            end else begin
                starve_nxt_s = starve_r + SW'(1'b1);
            end
        end else if (!empty_s) begin
            pop_s        = 1'b1;
            load_s       = 1'b1;
            starve_nxt_s = {SW{1'b0}};
        end else begin
            starve_nxt_s = {SW{1'b0}};
        end
    end

    // Starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_r <= {SW{1'b0}};
        end else begin
            starve_r <= starve_nxt_s;
        end
    end

    // Registered write port; address and data hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_r  <= 1'b0;
            write_r     <= {REG_AW{1'b0}};
            writedata_r <= {REG_DW{1'b0}};
        end else if (load_s) begin
            regwrite_r  <= 1'b1;
            write_r     <= out_rec_s.dst;
            writedata_r <= out_rec_s.data;
        end else begin
            regwrite_r  <= 1'b0;
        end
    end

    assign bus.alu_stall = stall_s;
    assign bus.md_ready  = md_ready_s;
    assign bus.regwrite  = regwrite_r;
    assign bus.write     = write_r;
    assign bus.writedata = writedata_r;
    assign bus.pending   = qmask_s | (regwrite_r ? reg_onehot(write_r) : {NREGS{1'b0}});

endmodule

// File: tb/tb_regs_wb_arb.sv
// Directed and scoreboarded checks of the write-back arbiter.
module tb_regs_wb_arb;
    import regs_pkg::*;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    regs_wb_arb_if bus();

    regs_wb_arb #(.DEPTH(4), .STARVE_MAX(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.alu_we   = 1'b0;
        bus.alu_dst  = 5'd0;
        bus.alu_data = 32'h0;
        bus.md_valid = 1'b0;
        bus.md_dst   = 5'd0;
        bus.md_data  = 32'h0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        nvec++; if (bus.regwrite !== 1'b0) begin nerr++; $display("FAIL rst_regwrite got=%b want=0", bus.regwrite); end
        nvec++; if (bus.md_ready !== 1'b0) begin nerr++; $display("FAIL rst_md_ready got=%b want=0", bus.md_ready); end
        nvec++; if (bus.pending !== 32'h0) begin nerr++; $display("FAIL rst_pending got=%h want=0", bus.pending); end
        nvec++; if (bus.alu_stall !== 1'b0) begin nerr++; $display("FAIL rst_alu_stall got=%b want=0", bus.alu_stall); end
        rst = 1'b0;
        next_cycle();
        nvec++; if (bus.regwrite !== 1'b0) begin nerr++; $display("FAIL rel_regwrite got=%b want=0", bus.regwrite); end
        nvec++; if (bus.pending !== 32'h0) begin nerr++; $display("FAIL rel_pending got=%h want=0", bus.pending); end
        nvec++; if (bus.md_ready !== 1'b1) begin nerr++; $display("FAIL rel_md_ready got=%b want=1", bus.md_ready); end
        // mid-cycle reset while a write sits on the output stage
        bus.alu_we = 1'b1; bus.alu_dst = 5'd3; bus.alu_data = 32'h0000CAFE;
        next_cycle();
        idle_inputs();
        nvec++; if (bus.regwrite !== 1'b1 || bus.write !== 5'd3) begin nerr++; $display("FAIL pre_rst_write got=%b/%0d want=1/3", bus.regwrite, bus.write); end
        #2;
        rst = 1'b1;
        #1;
        nvec++; if (bus.regwrite !== 1'b0) begin nerr++; $display("FAIL async_regwrite got=%b want=0", bus.regwrite); end
        nvec++; if (bus.write !== 5'd0 || bus.writedata !== 32'h0) begin nerr++; $display("FAIL async_wdata got=%0d/%h want=0/0", bus.write, bus.writedata); end
        nvec++; if (bus.pending !== 32'h0) begin nerr++; $display("FAIL async_pending got=%h want=0", bus.pending); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        nvec++; if (bus.regwrite !== 1'b0) begin nerr++; $display("FAIL post_rst_regwrite got=%b want=0", bus.regwrite); end
    endtask

    task automatic test_alu;
        bus.alu_we = 1'b1; bus.alu_dst = 5'd5; bus.alu_data = 32'h12345678;
        #2;
        nvec++; if (bus.alu_stall !== 1'b0) begin nerr++; $display("FAIL alu_stall got=%b want=0", bus.alu_stall); end
        next_cycle();
        idle_inputs();
        nvec++; if (bus.regwrite !== 1'b1) begin nerr++; $display("FAIL alu_regwrite got=%b want=1", bus.regwrite); end
        nvec++; if (bus.write !== 5'd5) begin nerr++; $display("FAIL alu_write got=%0d want=5", bus.write); end
        nvec++; if (bus.writedata !== 32'h12345678) begin nerr++; $display("FAIL alu_wdata got=%h want=12345678", bus.writedata); end
        nvec++; if (bus.pending !== 32'h00000020) begin nerr++; $display("FAIL alu_pending got=%h want=00000020", bus.pending); end
        next_cycle();
        nvec++; if (bus.regwrite !== 1'b0) begin nerr++; $display("FAIL alu_one_cycle got=%b want=0", bus.regwrite); end
        nvec++; if (bus.write !== 5'd5) begin nerr++; $display("FAIL alu_hold got=%0d want=5", bus.write); end
        bus.alu_we = 1'b1; bus.alu_dst = 5'd0; bus.alu_data = 32'h0000DEAD;
        #2;
        nvec++; if (bus.alu_stall !== 1'b0) begin nerr++; $display("FAIL r0_stall got=%b want=0", bus.alu_stall); end
        next_cycle();
        idle_inputs();
        nvec++; if (bus.regwrite !== 1'b0) begin nerr++; $display("FAIL r0_regwrite got=%b want=0", bus.regwrite); end
    endtask

    task automatic test_starve;
        logic [4:0]  exp_w;
        logic [31:0] exp_d;
        for (int c = 0; c <= 21; c++) begin
            bus.alu_we   = (c < 18);
            bus.alu_dst  = 5'd20;
            bus.alu_data = 32'hAAAA0014;
            bus.md_valid = (c < 4);
            bus.md_dst   = 5'(8 + c);
            bus.md_data  = 32'h100 + 32'(c);
            #2;
            nvec++; if (bus.alu_stall !== ((c == 8) || (c == 16))) begin nerr++; $display("FAIL starve_stall c=%0d got=%b want=%b", c, bus.alu_stall, (c == 8) || (c == 16)); end
            if (c <= 8) begin
                nvec++; if (bus.md_ready !== (c < 4)) begin nerr++; $display("FAIL starve_ready c=%0d got=%b want=%b", c, bus.md_ready, c < 4); end
            end
            if (c == 4) begin
                nvec++; if ((bus.pending & 32'h00000F00) !== 32'h00000F00) begin nerr++; $display("FAIL starve_pending got=%h want=bits 8-11", bus.pending); end
            end
            if (c == 21) begin
                nvec++; if (bus.regwrite !== 1'b0 || bus.pending !== 32'h0) begin nerr++; $display("FAIL starve_drain got=%b/%h want=0/0", bus.regwrite, bus.pending); end
            end else if (c >= 1) begin
                case (c)
                    9:       begin exp_w = 5'd8;  exp_d = 32'h100; end
                    17:      begin exp_w = 5'd9;  exp_d = 32'h101; end
                    19:      begin exp_w = 5'd10; exp_d = 32'h102; end
                    20:      begin exp_w = 5'd11; exp_d = 32'h103; end
                    default: begin exp_w = 5'd20; exp_d = 32'hAAAA0014; end
                endcase
                nvec++; if (bus.regwrite !== 1'b1 || bus.write !== exp_w || bus.writedata !== exp_d) begin nerr++; $display("FAIL starve_write c=%0d got=%b/%0d/%h want=1/%0d/%h", c, bus.regwrite, bus.write, bus.writedata, exp_w, exp_d); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_burst;
        logic [31:0] exp_pend [12];
        logic        exp_rdy  [7];
        int          j;
        exp_pend = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h8000001E, 32'h0000001E,
                     32'h0000003C, 32'h00000078, 32'h00000070, 32'h00000060,
                     32'h00000040, 32'h00000000};
        exp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        j = 1;
        for (int c = 0; c <= 11; c++) begin
            bus.alu_we   = (c < 4);
            bus.alu_dst  = 5'd31;
            bus.alu_data = 32'h31313131;
            bus.md_valid = (j <= 6);
            bus.md_dst   = 5'(j);
            bus.md_data  = 32'(j) * 32'h11;
            #2;
            if (c <= 6) begin
                nvec++; if (bus.md_ready !== exp_rdy[c]) begin nerr++; $display("FAIL burst_ready c=%0d got=%b want=%b", c, bus.md_ready, exp_rdy[c]); end
            end
            if (c >= 4) begin
                nvec++; if (bus.pending !== exp_pend[c]) begin nerr++; $display("FAIL burst_pending c=%0d got=%h want=%h", c, bus.pending, exp_pend[c]); end
            end
            if (c >= 5 && c <= 10) begin
                nvec++; if (bus.regwrite !== 1'b1 || bus.write !== 5'(c - 4) || bus.writedata !== 32'(c - 4) * 32'h11) begin nerr++; $display("FAIL burst_write c=%0d got=%b/%0d/%h want=1/%0d/%h", c, bus.regwrite, bus.write, bus.writedata, c - 4, 32'(c - 4) * 32'h11); end
            end
            if (c == 11) begin
                nvec++; if (bus.regwrite !== 1'b0) begin nerr++; $display("FAIL burst_end got=%b want=0", bus.regwrite); end
            end
            if (bus.md_valid && bus.md_ready) j++;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp_w [7];
        exp_w = '{5'd0, 5'd30, 5'd30, 5'd12, 5'd13, 5'd14, 5'd0};
        for (int c = 0; c <= 6; c++) begin
            bus.alu_we   = (c < 2);
            bus.alu_dst  = 5'd30;
            bus.alu_data = 32'h30303030;
            bus.md_valid = (c < 3);
            bus.md_dst   = 5'(12 + c);
            bus.md_data  = 32'(12 + c);
            #2;
            if (c == 2 || c == 3) begin
                nvec++; if (dut.count_s !== 3'd2) begin nerr++; $display("FAIL simul_count c=%0d got=%0d want=2", c, dut.count_s); end
            end
            if (c >= 1 && c <= 5) begin
                nvec++; if (bus.regwrite !== 1'b1 || bus.write !== exp_w[c]) begin nerr++; $display("FAIL simul_write c=%0d got=%b/%0d want=1/%0d", c, bus.regwrite, bus.write, exp_w[c]); end
            end
            if (c == 6) begin
                nvec++; if (bus.regwrite !== 1'b0) begin nerr++; $display("FAIL simul_end got=%b want=0", bus.regwrite); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_random;
        wb_rec_t     sbq[$];
        wb_rec_t     rec;
        int          produced;
        logic        exp_alu;
        logic        alu_hold;
        logic        md_hold;
        logic        done;
        logic [4:0]  exp_dst;
        logic [31:0] exp_data;
        produced = 0; exp_alu = 1'b0; alu_hold = 1'b0; md_hold = 1'b0; done = 1'b0;
        exp_dst = 5'd0; exp_data = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (exp_alu) begin
                nvec++; if (bus.regwrite !== 1'b1 || bus.write !== exp_dst || bus.writedata !== exp_data) begin nerr++; $display("FAIL rnd_alu got=%b/%0d/%h want=1/%0d/%h", bus.regwrite, bus.write, bus.writedata, exp_dst, exp_data); end
            end else if (bus.regwrite === 1'b1) begin
                nvec++;
                if (sbq.size() == 0) begin
                    nerr++; $display("FAIL rnd_spurious got=%0d/%h want=no write", bus.write, bus.writedata);
                end else begin
                    rec = sbq.pop_front();
                    if (bus.write !== rec.dst || bus.writedata !== rec.data) begin nerr++; $display("FAIL rnd_md got=%0d/%h want=%0d/%h", bus.write, bus.writedata, rec.dst, rec.data); end
                end
            end
            if (produced == 20 && sbq.size() == 0 && !md_hold) begin
                done = 1'b1;
                break;
            end
            if (!alu_hold) begin
                bus.alu_we   = 1'($urandom_range(0, 1));
                bus.alu_dst  = 5'($urandom_range(0, 31));
                bus.alu_data = $urandom;
            end
            if (!md_hold) begin
                bus.md_valid = 1'b0;
                if (produced < 20 && $urandom_range(0, 2) != 0) begin
                    bus.md_valid = 1'b1;
                    bus.md_dst   = 5'($urandom_range(0, 31));
                    bus.md_data  = $urandom;
                    md_hold      = 1'b1;
                end
            end
            #2;
            exp_alu  = bus.alu_we && (bus.alu_dst != 5'd0) && !bus.alu_stall;
            alu_hold = bus.alu_we && (bus.alu_dst != 5'd0) && bus.alu_stall;
            exp_dst  = bus.alu_dst;
            exp_data = bus.alu_data;
            if (bus.md_valid && bus.md_ready) begin
                if (bus.md_dst != 5'd0) begin
                    rec.dst  = bus.md_dst;
                    rec.data = bus.md_data;
                    sbq.push_back(rec);
                end
                produced++;
                md_hold = 1'b0;
            end
            next_cycle();
        end
        nvec++; if (!done) begin nerr++; $display("FAIL rnd_timeout got=%0d produced/%0d queued want=20/0", produced, sbq.size()); end
        idle_inputs();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_alu();
        test_starve();
        test_burst();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
